apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB requester that sits directly upstream of the APB memory slave. It converts a simple valid/ready command stream into single APB transfers (SETUP then ACCESS), waits on `pready`, and returns read data or completion status on a valid/ready response channel. A per-transfer timeout guards against a slave that never asserts `pready`.

## Interface
- `ADDR_WIDTH`, default 10: APB address width; matches the memory slave.
- `DATA_WIDTH`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles before abort; legal range ≥ 2.

Ports:
- `pclk`  in  1  clock.
- `PRESETn`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when high together with `req_valid`.
- `req_addr`  in  ADDR_WIDTH  transfer address.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers.
- `rsp_err`  out  1  1 = timeout abort.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pready`  in  1  APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1, `psel`=0, `penable`=0.
  - On `req_valid`&&`req_ready`, register `req_addr`, `req_write` and `req_wdata` into `paddr`, `pwrite` and `pwdata`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then go to ACCESS. Clear the wait counter.
- ACCESS:
  - `psel`=1, `penable`=1.
  - If `pready`=1: capture `rsp_rdata` (`prdata` for a read, 0 for a write), set `rsp_err`=0, go to RESP.
  - Else if the wait counter equals `TIMEOUT`-1: set `rsp_rdata`=0, `rsp_err`=1, go to RESP.
  - Else increment the wait counter.
  - Result: at most `TIMEOUT` ACCESS cycles per transfer.
- RESP:
  - `rsp_valid`=1, `req_ready`=0, `psel`=0, `penable`=0.
  - Hold `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1, then go to IDLE.
- `paddr`, `pwrite` and `pwdata` are held constant from SETUP through the end of ACCESS. Outside a transfer they hold their last value.
- The wait counter is `$clog2(TIMEOUT)` bits wide and never wraps. It clears on SETUP entry.
- Commands are not accepted in SETUP, ACCESS or RESP (`req_ready`=0). A held `req_valid` is accepted on the next IDLE cycle.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State goes to IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid` and `rsp_err` = 0.
  - `paddr`, `pwdata` and `rsp_rdata` = 0.
  - `req_ready`=1 after reset release.
  - An aborted transfer produces no response.
- The memory slave asserts `pready` in the first ACCESS cycle, which gives this sequence:
  - Cycle 0: accept.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - Cycle 3: RESP (`rsp_valid`=1).
  - Next accept at the earliest in cycle 4, i.e. 4 cycles per transfer with `rsp_ready` held at 1.
- Each extra `pready`=0 cycle adds one cycle. A timeout response appears `TIMEOUT`+1 cycles after SETUP.
- All outputs are registered or decoded from state only. There is no combinational path from `pready`/`prdata` to any output.

## Structure
- Shared package `apb_pkg`: holds the state typedef `apb_mst_state_t` {IDLE, SETUP, ACCESS, RESP} and the default width constants `APB_ADDR_W`=10 and `APB_DATA_W`=32.
- A single module; no sub-module. The wait counter stays inline.

## Test plan
- Paired with the memory slave: write 0xDEADBEEF to address 0x3A0, then read 0x3A0. The read response returns `rsp_rdata`=0xDEADBEEF with `rsp_err`=0, and each transfer takes 4 cycles.
- Wait states: a slave model holds `pready` low for 3 ACCESS cycles, then returns 0x12345678. Response is 0x12345678, `rsp_err`=0, `penable` high for 4 cycles, and `paddr` stays stable throughout.
- Timeout: `pready` tied to 0 with `TIMEOUT`=16. Exactly 16 ACCESS cycles occur, then `rsp_err`=1 and `rsp_rdata`=0, then IDLE.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP. `rsp_valid` and data stay stable, `req_ready` stays 0, and a pending `req_valid` is accepted only after the handshake.
- Reset mid-ACCESS: assert `PRESETn` low during a waited read. `psel`/`penable` drop immediately, no `rsp_valid` appears, and after release a new write completes normally.
- Back-to-back: 8 queued writes to addresses 0..7 followed by 8 reads. All read data matches, with no gap beyond 4 cycles per transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer and
// returns read data or a timeout status on a valid/ready response channel.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_mst_state_t        state_r;
  apb_mst_state_t        state_s;
  logic [CNT_W-1:0]      wait_cnt_r;
  logic                  wait_last_s;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic                  pwrite_r;
  logic [DATA_WIDTH-1:0] pwdata_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;

  assign wait_last_s = (wait_cnt_r == CNT_LAST);

  // Next-state decode; pready only steers the state, never an output directly.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = SETUP;
        else           state_s = IDLE;
      end
      SETUP: state_s = ACCESS;
      ACCESS: begin
        if (pready)           state_s = RESP;
        else if (wait_last_s) state_s = RESP;
        else                  state_s = ACCESS;
      end
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Capture the command on acceptance; held until the next accepted command.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_r  <= {ADDR_WIDTH{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= {DATA_WIDTH{1'b0}};
    end else if (state_r == IDLE && req_valid) begin
      paddr_r  <= req_addr;
      pwrite_r <= req_write;
      pwdata_r <= req_wdata;
    end
  end

  // ACCESS wait counter: cleared in SETUP, saturates at TIMEOUT-1.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == SETUP) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ACCESS && !pready && !wait_last_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // Response capture at the end of ACCESS; held through RESP.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (state_r == ACCESS) begin
      if (pready) begin
        rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
        rsp_err_r   <= 1'b0;
      end else if (wait_last_s) begin
        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        rsp_err_r   <= 1'b1;
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign psel      = (state_r == SETUP) || (state_r == ACCESS);
  assign penable   = (state_r == ACCESS);
  assign rsp_valid = (state_r == RESP);
  assign paddr     = paddr_r;
  assign pwrite    = pwrite_r;
  assign pwdata    = pwdata_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master with a wait-state-programmable APB slave model.
module tb_apb_cmd_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          PRESETn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready;
  logic [DW-1:0] pwdata, prdata;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic [7:0]    acc;
  } exp_t;

  exp_t          exp_q[$];
  int            wait_q[$];
  logic [DW-1:0] ref_mem[1024];
  logic [DW-1:0] slv_mem[1024];
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int rsp_mode = 0;   // 0: rsp_ready=1, 1: random, 2: rsp_ready=0
  int tput_on  = 0;
  int last_accept = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cycle);
    end
  endtask

  always @(posedge pclk) cycle <= cycle + 1;

  // Response-ready driver.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge pclk); #1;
      if (rsp_mode == 0)      rsp_ready = 1'b1;
      else if (rsp_mode == 2) rsp_ready = 1'b0;
      else                    rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // APB slave model: answers after the number of wait cycles queued for this transfer.
  int cur_wait = 0;
  int acc_cnt  = 0;
  initial begin
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(posedge pclk or negedge PRESETn); #1;
      pready = 1'b0;
      prdata = $urandom;
      if (PRESETn && psel && !penable) begin
        cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 1000;
        acc_cnt  = 0;
      end else if (PRESETn && psel && penable) begin
        if (acc_cnt == cur_wait) begin
          pready = 1'b1;
          if (pwrite) slv_mem[paddr] = pwdata;
          else        prdata = slv_mem[paddr];
        end
        acc_cnt++;
      end
    end
  end

  // Monitor: protocol stability and scoreboard comparison on each response.
  int            acc_seen = 0;
  logic          in_resp = 1'b0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, h_rdata;
  logic          s_write, h_err;
  exp_t          cur;
  always @(negedge pclk) begin
    if (!PRESETn) begin
      in_resp  = 1'b0;
      acc_seen = 0;
    end else begin
      if (penable && !psel) chk("penable_without_psel", 1, 0);
      if (psel && !penable) begin
        acc_seen = 0;
        s_addr = paddr; s_wdata = pwdata; s_write = pwrite;
      end
      if (psel && penable) begin
        acc_seen++;
        chk("paddr_stable", paddr, s_addr);
        chk("pwrite_stable", pwrite, s_write);
        if (s_write) chk("pwdata_stable", pwdata, s_wdata);
      end
      if (rsp_valid) begin
        if (req_ready) chk("req_ready_in_resp", req_ready, 0);
        if (!in_resp) begin
          in_resp = 1'b1;
          h_rdata = rsp_rdata; h_err = rsp_err;
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", rsp_err, cur.err);
            chk("access_cycles", acc_seen, cur.acc);
          end
        end else begin
          chk("rsp_rdata_hold", rsp_rdata, h_rdata);
          chk("rsp_err_hold", rsp_err, h_err);
        end
        if (rsp_ready) in_resp = 1'b0;
      end
    end
  end

  // Issue one command and record the expected response from the reference model.
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input int waits, input int gap);
    exp_t e;
    bit   ok = 0;
    @(posedge pclk); #1;
    req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge pclk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (tput_on != 0 && last_accept >= 0) chk("throughput", cycle - last_accept, 4);
    last_accept = cycle;
    e.acc = (waits >= TO) ? 8'(TO) : 8'(waits + 1);
    if (waits >= TO) begin
      e.rdata = '0; e.err = 1'b1;
    end else if (w) begin
      ref_mem[a] = d; e.rdata = '0; e.err = 1'b0;
    end else begin
      e.rdata = ref_mem[a]; e.err = 1'b0;
    end
    exp_q.push_back(e);
    wait_q.push_back(waits);
    @(posedge pclk); #1;
    req_valid = 1'b0;
    repeat (gap) @(posedge pclk);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      @(negedge pclk);
      if (exp_q.size() == 0 && req_ready) return;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w8;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'hA5A50000 ^ 32'(i * 7);
      slv_mem[i] = 32'hA5A50000 ^ 32'(i * 7);
    end
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    PRESETn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;
    @(negedge pclk);
    chk("rst_req_ready", req_ready, 1);

    // Write then read back with a zero-wait slave, four cycles per transfer.
    rsp_mode = 0; tput_on = 1; last_accept = -1;
    issue(10'h3A0, 1'b1, 32'hDEADBEEF, 0, 0);
    issue(10'h3A0, 1'b0, 32'h0, 0, 0);
    drain();
    tput_on = 0;

    // Three wait states, then timeout with pready held low.
    issue(10'h055, 1'b1, 32'h12345678, 0, 0);
    issue(10'h055, 1'b0, 32'h0, 3, 0);
    issue(10'h010, 1'b0, 32'h0, TO, 0);
    issue(10'h011, 1'b1, 32'hCAFEF00D, TO - 1, 0);
    drain();

    // Backpressure: response held for 5 cycles, the next command must wait.
    rsp_mode = 2;
    issue(10'h3A0, 1'b0, 32'h0, 0, 0);
    fork
      issue(10'h021, 1'b1, 32'h0BADC0DE, 0, 0);
      begin
        for (int t = 0; t < 50 && !rsp_valid; t++) @(negedge pclk);
        repeat (5) begin
          @(negedge pclk);
          chk("bp_rsp_valid", rsp_valid, 1);
          chk("bp_req_ready", req_ready, 0);
        end
        rsp_mode = 0;
      end
    join
    drain();

    // Back-to-back: 8 writes then 8 reads with no idle gaps.
    tput_on = 1; last_accept = -1;
    for (int i = 0; i < 8; i++) issue(10'(i), 1'b1, 32'h1000 + 32'(i * 17), 0, 0);
    for (int i = 0; i < 8; i++) issue(10'(i), 1'b0, 32'h0, 0, 0);
    drain();
    tput_on = 0;

    // Reset in the middle of a waited read: no response may follow.
    issue(10'h3A0, 1'b0, 32'h0, 10, 0);
    repeat (3) @(posedge pclk);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    wait_q.delete();
    repeat (2) @(posedge pclk);
    #1 PRESETn = 1'b1;
    repeat (25) @(negedge pclk);
    issue(10'h0F0, 1'b1, 32'h5A5A1234, 0, 0);
    issue(10'h0F0, 1'b0, 32'h0, 1, 0);
    drain();

    // Randomized traffic with random backpressure, wait states and timeouts.
    rsp_mode = 1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r < 15)      w8 = r % 4;
      else if (r < 17) w8 = TO - 1;
      else             w8 = TO;
      issue(($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom, w8, $urandom_range(0, 2));
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
